fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF-stage producer that feeds the IF/ID pipeline register: generates InstrF, PCF and PCPlus4F each cycle.
- Owns the PC register and the request/response handshake to instruction memory, with one outstanding fetch at a time.
- Handles hazard-unit stalls and EX-stage redirects (taken branch/jump).
- Drives a NOP bubble whenever no fresh instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when ValidF=0 (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- StallF  in  1  hazard unit: IF/ID must not consume the current output.
- PCSrcE  in  1  redirect request from EX.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (word aligned).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- InstrF  out  32  instruction to IF/ID.
- PCF  out  32  PC of InstrF.
- PCPlus4F  out  32  PCF+4.
- ValidF  out  1  InstrF/PCF hold a real fetched instruction.

Behaviour:
- Reset (async, immediate): pc_q=RESET_PC, state=REQ, buffer empty.
  - Outputs during reset: ValidF=0, InstrF=NOP_INSTR, PCF=RESET_PC, PCPlus4F=RESET_PC+4, imem_req=0.
  - Reset mid-fetch abandons the outstanding request. Any response arriving while in REQ is ignored.
- Output buffer: buf_valid, buf_instr, buf_pc, all registered.
  - InstrF = buf_valid ? buf_instr : NOP_INSTR.
  - PCF = buf_pc; PCPlus4F = buf_pc+4, mod 2^32.
  - ValidF = buf_valid.
- Consume rule: at a rising edge with StallF=0, the buffer is consumed and buf_valid clears, unless it is reloaded at the same edge.
- State machine (states REQ, WAIT, KILL):
  - REQ:
    - imem_req=1 iff (!buf_valid || !StallF) && !PCSrcE; imem_addr=pc_q.
    - imem_req && imem_ready -> WAIT.
  - WAIT:
    - imem_req=0.
    - imem_rvalid: buf_valid=1, buf_instr=imem_rdata, buf_pc=pc_q; pc_q<=pc_q+4 (wraps 0xFFFFFFFC -> 0x0); -> REQ.
  - KILL:
    - imem_req=0.
    - imem_rvalid: response discarded, buffer and pc_q untouched; -> REQ.
- Redirect (PCSrcE=1 at an edge) has priority over stall and over response capture.
  - pc_q<=PCTargetE with bits[1:0] forced to 00; buf_valid<=0.
  - Next state: from WAIT -> KILL. From KILL -> KILL. From REQ -> REQ (imem_req is suppressed while PCSrcE=1, so no request can be accepted).
  - Redirect in WAIT with imem_rvalid in the same cycle: the response is discarded and the next state is REQ (not KILL).
- Throughput: at most one instruction per 2 cycles (REQ + >=1 WAIT).
- imem_addr is held stable while imem_req=1 and !imem_ready.
- Latency: accept at edge N, rvalid in cycle N+k gives ValidF=1 from edge N+k.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, KILL}.
  - NOP_INSTR and RESET_PC default constants.
  - PC_INC = 32'd4.
- Sub-module fetch_buffer: holding register with load, consume and flush inputs and combinational NOP substitution. Instantiated once.

Test Plan:
- Reset: assert reset mid-WAIT, release -> imem_req=1, imem_addr=0x0, ValidF=0, InstrF=0x00000013, PCPlus4F=0x4.
- Sequential fetch, ready=1, rvalid 1 cycle after accept, rdata 0x00500093 then 0x00108113 -> ValidF=1 with InstrF=0x00500093, PCF=0x0, PCPlus4F=0x4; next imem_addr=0x4, then PCF=0x4.
- Stall: buffer valid, StallF=1 for 3 cycles -> InstrF/PCF held, imem_req=0 after the next fetch is parked; StallF=0 -> consumed, next request issues.
- Redirect in WAIT: PCSrcE=1, PCTargetE=0x100, response 0xDEADBEEF arrives 2 cycles later -> ValidF stays 0, InstrF=NOP, then imem_addr=0x100.
- Simultaneous events:
  - PCSrcE=1 and StallF=1 with buffer valid -> buffer flushed (ValidF=0 next cycle), pc=target.
  - PCSrcE=1 together with imem_rvalid in WAIT -> data dropped, state REQ.
- Boundaries:
  - Fetch at pc 0xFFFFFFFC -> PCPlus4F=0x0, next imem_addr=0x0.
  - PCTargetE=0x103 -> imem_addr=0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_INC            = 32'd4;
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: IF/ID-facing holding register with NOP substitution
// Ports: clk, reset (async high); load/load_instr/load_pc capture a response,
// consume drops the held entry, flush kills it with top priority;
// valid/instr/pc present the held entry (instr is NOP when empty).
module fetch_buffer import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = flush ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : valid_q;
        instr_d = load ? load_instr : instr_q;
        pc_d    = load ? load_pc : pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = valid_q ? instr_q : NOP_INSTR;
    assign pc    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with one outstanding imem fetch, stall and redirect handling
// Ports: clk, reset (async high); StallF/PCSrcE/PCTargetE from hazard unit and EX;
// imem_req/imem_addr/imem_ready request channel, imem_rvalid/imem_rdata response;
// InstrF/PCF/PCPlus4F/ValidF to the IF/ID register.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         buf_valid, load;

    always_comb begin
        imem_req = !reset && state_q == REQ && (!buf_valid || !StallF) && !PCSrcE;
        load     = state_q == WAIT && imem_rvalid && !PCSrcE;
        pc_d     = PCSrcE ? align_word(PCTargetE) : load ? pc_q + PC_INC : pc_q;
        // A redirect while a fetch is in flight must swallow its response,
        // unless that response is arriving right now.
        state_d  = PCSrcE ? ((state_q == REQ || imem_rvalid) ? REQ : KILL)
                 : state_q == REQ ? ((imem_req && imem_ready) ? WAIT : REQ)
                 : imem_rvalid ? REQ : state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .consume    (!StallF),
        .flush      (PCSrcE),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .valid      (buf_valid),
        .instr      (InstrF),
        .pc         (PCF)
    );

    assign imem_addr = pc_q;
    assign PCPlus4F  = PCF + PC_INC;
    assign ValidF    = buf_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1, StallF = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0, imem_rdata = '0;
    logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic        imem_req, ValidF;
    logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
    int          vecs = 0, errs = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rst_first_req got=%0h exp=1", imem_req); end
        @(negedge clk);
        imem_ready = 1'b0;
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hAAAA_AAAA;
        #1;
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_in_req got=%0h exp=0", imem_req); end
        vecs++; if (ValidF !== 1'b0) begin errs++; $display("FAIL rst_in_valid got=%0h exp=0", ValidF); end
        vecs++; if (InstrF !== 32'h13) begin errs++; $display("FAIL rst_in_instr got=%08h exp=00000013", InstrF); end
        vecs++; if (PCPlus4F !== 32'h4) begin errs++; $display("FAIL rst_in_pc4 got=%08h exp=00000004", PCPlus4F); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL rst_rel_req got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        vecs++; if (ValidF !== 1'b0 || InstrF !== 32'h13 || PCF !== 32'h0 || PCPlus4F !== 32'h4) begin errs++; $display("FAIL rst_rel_out got=%0h/%08h/%08h/%08h exp=0/00000013/00000000/00000004", ValidF, InstrF, PCF, PCPlus4F); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0) begin errs++; $display("FAIL rst_stray_rvalid got=%0h exp=0", ValidF); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        #1;
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL seq_wait_req got=%0h exp=0", imem_req); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b1 || InstrF !== 32'h0050_0093) begin errs++; $display("FAIL seq_i0 got=%0h/%08h exp=1/00500093", ValidF, InstrF); end
        vecs++; if (PCF !== 32'h0 || PCPlus4F !== 32'h4) begin errs++; $display("FAIL seq_pc0 got=%08h/%08h exp=00000000/00000004", PCF, PCPlus4F); end
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errs++; $display("FAIL seq_addr1 got=%0h/%08h exp=1/00000004", imem_req, imem_addr); end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || InstrF !== 32'h13) begin errs++; $display("FAIL seq_consumed got=%0h/%08h exp=0/00000013", ValidF, InstrF); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0010_8113;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b1 || InstrF !== 32'h0010_8113 || PCF !== 32'h4 || PCPlus4F !== 32'h8) begin errs++; $display("FAIL seq_i1 got=%0h/%08h/%08h/%08h exp=1/00108113/00000004/00000008", ValidF, InstrF, PCF, PCPlus4F); end
        vecs++; if (imem_addr !== 32'h8) begin errs++; $display("FAIL seq_addr2 got=%08h exp=00000008", imem_addr); end
    endtask

    task automatic test_stall();
        StallF = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL stall_req%0d got=%0h exp=0", i, imem_req); end
            vecs++; if (ValidF !== 1'b1 || InstrF !== 32'h0010_8113 || PCF !== 32'h4) begin errs++; $display("FAIL stall_hold%0d got=%0h/%08h/%08h exp=1/00108113/00000004", i, ValidF, InstrF, PCF); end
            @(negedge clk);
        end
        StallF = 1'b0;
        #1;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errs++; $display("FAIL stall_release got=%0h/%08h exp=1/00000008", imem_req, imem_addr); end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || imem_req !== 1'b0) begin errs++; $display("FAIL stall_consumed got=%0h/%0h exp=0/0", ValidF, imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0113;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b1 || PCF !== 32'h8 || InstrF !== 32'h0000_0113) begin errs++; $display("FAIL stall_next got=%0h/%08h/%08h exp=1/00000008/00000113", ValidF, PCF, InstrF); end
    endtask

    task automatic test_redirect_wait();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || imem_req !== 1'b0) begin errs++; $display("FAIL rdw_kill got=%0h/%0h exp=0/0", ValidF, imem_req); end
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || InstrF !== 32'h13) begin errs++; $display("FAIL rdw_drop got=%0h/%08h exp=0/00000013", ValidF, InstrF); end
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL rdw_addr got=%0h/%08h exp=1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_stall();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h00A0_0513;
        @(negedge clk);
        imem_rvalid = 1'b0;
        StallF = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        #1;
        vecs++; if (ValidF !== 1'b1 || PCF !== 32'h100 || imem_req !== 1'b0) begin errs++; $display("FAIL rds_pre got=%0h/%08h/%0h exp=1/00000100/0", ValidF, PCF, imem_req); end
        @(negedge clk);
        PCSrcE = 1'b0;
        StallF = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || InstrF !== 32'h13) begin errs++; $display("FAIL rds_flush got=%0h/%08h exp=0/00000013", ValidF, InstrF); end
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errs++; $display("FAIL rds_addr got=%0h/%08h exp=1/00000200", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_rvalid();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        PCSrcE = 1'b1;
        PCTargetE = 32'h300;
        @(negedge clk);
        imem_rvalid = 1'b0;
        PCSrcE = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b0 || InstrF !== 32'h13) begin errs++; $display("FAIL rdr_drop got=%0h/%08h exp=0/00000013", ValidF, InstrF); end
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errs++; $display("FAIL rdr_req got=%0h/%08h exp=1/00000300", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        imem_ready = 1'b1;
        #1;
        vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr got=%08h exp=fffffffc", imem_addr); end
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0073;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        vecs++; if (ValidF !== 1'b1 || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin errs++; $display("FAIL wrap_pc got=%0h/%08h/%08h exp=1/fffffffc/00000000", ValidF, PCF, PCPlus4F); end
        vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL wrap_next got=%08h exp=00000000", imem_addr); end
    endtask

    task automatic test_misaligned();
        PCSrcE = 1'b1;
        PCTargetE = 32'h103;
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL misalign got=%0h/%08h exp=1/00000100", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_redirect_rvalid();
        test_wrap();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
